// File: rtl/mesi_isc_snoop_seq.sv
// ---------------------------------------------------------------------------
// mesi_isc_snoop_seq
//
// Snoop sequencer for the MESI inter-cache coherence controller. It takes one
// broadcast at a time from the broadcast FIFO and runs it in three phases:
//   1. IDLE   : pop the FIFO head and latch its type, origin, tag and address.
//   2. SNOOP  : send WR_SNOOP / RD_SNOOP to every CPU except the origin. Each
//               port drops back to NOP once its ack is seen.
//   3. ENABLE : after every port has acked, send EN_WR / EN_RD to the origin.
//               The origin's ack ends the broadcast.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   broad_valid_i       broadcast FIFO holds an entry
//   broad_type_i        head entry type (1 = WR, 2 = RD, anything else = RD)
//   broad_cpu_id_i      head entry originating CPU (0..3)
//   broad_id_i          head entry tag
//   broad_addr_i        head entry line address
//   broad_pop_o         one-cycle pop strobe to the broadcast FIFO
//   cbus_ack3_i..0_i    per-CPU coherence-bus acknowledge
//   cbus_cmd3_o..0_o    per-CPU coherence command
//                       (NOP=0, WR_SNOOP=1, RD_SNOOP=2, EN_WR=3, EN_RD=4)
//   cbus_addr_o         shared coherence-bus address of the active broadcast
//   active_id_o         tag of the active broadcast
//   busy_o              sequencer is not IDLE
//   snoop_timeout_o     sticky snoop timeout flag (only with the macro below)
//
// Configuration macro
//   MESI_ISC_SNOOP_TIMEOUT_EN : when defined, an 8-bit counter limits SNOOP to
//   TIMEOUT_CYCLES cycles. On expiry the sequencer forces ENABLE and sets
//   snoop_timeout_o. When undefined, SNOOP waits for all acks indefinitely.
// ---------------------------------------------------------------------------
module mesi_isc_snoop_seq #(
  parameter int CBUS_CMD_WIDTH   = 3,
  parameter int ADDR_WIDTH       = 32,
  parameter int BROAD_TYPE_WIDTH = 2,
  parameter int BROAD_ID_WIDTH   = 5,
  parameter int TIMEOUT_CYCLES   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        broad_valid_i,
  input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
  input  logic [1:0]                  broad_cpu_id_i,
  input  logic [BROAD_ID_WIDTH-1:0]   broad_id_i,
  input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
  output logic                        broad_pop_o,
  input  logic                        cbus_ack3_i,
  input  logic                        cbus_ack2_i,
  input  logic                        cbus_ack1_i,
  input  logic                        cbus_ack0_i,
  output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd3_o,
  output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd2_o,
  output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd1_o,
  output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd0_o,
  output logic [ADDR_WIDTH-1:0]       cbus_addr_o,
  output logic [BROAD_ID_WIDTH-1:0]   active_id_o,
  output logic                        busy_o
`ifdef MESI_ISC_SNOOP_TIMEOUT_EN
  ,
  output logic                        snoop_timeout_o
`endif
);

  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SNOOP  = 2'd1,
    ENABLE = 2'd2
  } state_t;

  state_t                                state_q, state_d;
  logic [3:0]                            done_q, done_d;
  logic [3:0][CBUS_CMD_WIDTH-1:0]        cmd_q, cmd_d;
  logic                                  is_wr_q;
  logic [1:0]                            origin_q;
  logic                                  latch_en;
  logic                                  new_is_wr;
  logic [3:0]                            ack;
  logic [3:0]                            ack_hit;
  logic                                  snoop_all_done;
  logic                                  tmo_expire;

  assign ack = {cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i};

  // Any type other than WR (1) is handled as a read.
  assign new_is_wr = (broad_type_i == BROAD_TYPE_WIDTH'(1));

  assign cbus_cmd3_o = cmd_q[3];
  assign cbus_cmd2_o = cmd_q[2];
  assign cbus_cmd1_o = cmd_q[1];
  assign cbus_cmd0_o = cmd_q[0];

`ifdef MESI_ISC_SNOOP_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt_q;

  // The counter starts at 0 on the first SNOOP cycle, so expiry on
  // TMO_LAST gives exactly TIMEOUT_CYCLES cycles in SNOOP.
  assign tmo_expire = (state_q == SNOOP) && (tmo_cnt_q == TMO_LAST);

  // SNOOP-cycle counter and sticky timeout flag. The flag is raised only when
  // the timeout is what forces ENABLE, not when the last ack and the expiry
  // happen in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q       <= 8'd0;
      snoop_timeout_o <= 1'b0;
    end else begin
      if (state_q == SNOOP) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end else begin
        tmo_cnt_q <= 8'd0;
      end
      if (tmo_expire && !snoop_all_done) begin
        snoop_timeout_o <= 1'b1;
      end
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  // Next-state and next-command logic. The pop strobe is a decode of the
  // IDLE state register together with FIFO valid. This lets the FIFO advance
  // in the same cycle the head is latched. It is gated by rst so that it
  // stays low while reset is held.
  always_comb begin
    state_d        = state_q;
    done_d         = done_q;
    cmd_d          = cmd_q;
    broad_pop_o    = 1'b0;
    latch_en       = 1'b0;
    ack_hit        = 4'b0000;
    snoop_all_done = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_d = '0;
        if (broad_valid_i && rst) begin
          broad_pop_o = 1'b1;
          latch_en    = 1'b1;
          state_d     = SNOOP;
          done_d      = 4'b0001 << broad_cpu_id_i;
          for (int p = 0; p < 4; p++) begin
            if (2'(p) == broad_cpu_id_i) begin
              cmd_d[p] = CMD_NOP;
            end else begin
              cmd_d[p] = new_is_wr ? CMD_WR_SNOOP : CMD_RD_SNOOP;
            end
          end
        end
      end

      SNOOP: begin
        // Only ports still driving a snoop command can complete. Acks on
        // NOP ports, including the origin, are ignored.
        for (int p = 0; p < 4; p++) begin
          ack_hit[p] = ack[p] && (cmd_q[p] != CMD_NOP);
        end
        done_d         = done_q | ack_hit;
        snoop_all_done = &done_d;
        if (snoop_all_done || tmo_expire) begin
          state_d = ENABLE;
          for (int p = 0; p < 4; p++) begin
            if (2'(p) == origin_q) begin
              cmd_d[p] = is_wr_q ? CMD_EN_WR : CMD_EN_RD;
            end else begin
              cmd_d[p] = CMD_NOP;
            end
          end
        end else begin
          for (int p = 0; p < 4; p++) begin
            if (done_d[p]) begin
              cmd_d[p] = CMD_NOP;
            end
          end
        end
      end

      ENABLE: begin
        if (ack[origin_q]) begin
          state_d = IDLE;
          cmd_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cmd_d   = '0;
      end
    endcase
  end

  // State, done bits, command registers and the fields latched at pop time.
  // The address and tag hold their value until the next pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      done_q      <= 4'b0000;
      cmd_q       <= '0;
      is_wr_q     <= 1'b0;
      origin_q    <= 2'd0;
      cbus_addr_o <= '0;
      active_id_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      cmd_q   <= cmd_d;
      busy_o  <= (state_d != IDLE);
      if (latch_en) begin
        is_wr_q     <= new_is_wr;
        origin_q    <= broad_cpu_id_i;
        cbus_addr_o <= broad_addr_i;
        active_id_o <= broad_id_i;
      end
    end
  end

endmodule

// File: tb/tb_mesi_isc_snoop_seq.sv
// ---------------------------------------------------------------------------
// tb_mesi_isc_snoop_seq
//
// Directed bench for mesi_isc_snoop_seq. Each broadcast entry is pushed to a
// scoreboard queue when it is offered on the FIFO interface. The entry is
// popped from the queue when the DUT strobes broad_pop_o. The following
// cycle's tag, address and snoop command pattern are then checked against
// that entry. Per-cycle ack/command behaviour is checked with directed steps.
// The timeout scenario is compiled only when MESI_ISC_SNOOP_TIMEOUT_EN is set.
// ---------------------------------------------------------------------------
module tb_mesi_isc_snoop_seq;

  localparam int CW = 3;
  localparam int AW = 32;
  localparam int TW = 2;
  localparam int IW = 5;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [1:0]    origin;
    logic [TW-1:0] btype;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          broad_valid;
  logic [TW-1:0] broad_type;
  logic [1:0]    broad_cpu_id;
  logic [IW-1:0] broad_id;
  logic [AW-1:0] broad_addr;
  logic          broad_pop;
  logic [3:0]    acks;
  logic [CW-1:0] cmd3, cmd2, cmd1, cmd0;
  logic [AW-1:0] cbus_addr;
  logic [IW-1:0] active_id;
  logic          busy;
  logic [11:0]   cmds;
`ifdef MESI_ISC_SNOOP_TIMEOUT_EN
  logic          snoop_timeout;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  entry_t exp_q[$];
  entry_t fifo_q[$];

  always #5 clk = ~clk;

  assign cmds = {cmd3, cmd2, cmd1, cmd0};

  mesi_isc_snoop_seq #(
    .CBUS_CMD_WIDTH  (CW),
    .ADDR_WIDTH      (AW),
    .BROAD_TYPE_WIDTH(TW),
    .BROAD_ID_WIDTH  (IW),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .broad_valid_i  (broad_valid),
    .broad_type_i   (broad_type),
    .broad_cpu_id_i (broad_cpu_id),
    .broad_id_i     (broad_id),
    .broad_addr_i   (broad_addr),
    .broad_pop_o    (broad_pop),
    .cbus_ack3_i    (acks[3]),
    .cbus_ack2_i    (acks[2]),
    .cbus_ack1_i    (acks[1]),
    .cbus_ack0_i    (acks[0]),
    .cbus_cmd3_o    (cmd3),
    .cbus_cmd2_o    (cmd2),
    .cbus_cmd1_o    (cmd1),
    .cbus_cmd0_o    (cmd0),
    .cbus_addr_o    (cbus_addr),
    .active_id_o    (active_id),
    .busy_o         (busy)
`ifdef MESI_ISC_SNOOP_TIMEOUT_EN
    ,
    .snoop_timeout_o(snoop_timeout)
`endif
  );

  // Expected snoop pattern: every port except the origin gets WR_SNOOP for
  // type 1 and RD_SNOOP for any other type.
  function automatic logic [11:0] snoop_pat(input logic [1:0] origin, input logic [TW-1:0] t);
    logic [11:0] r;
    r = '0;
    for (int p = 0; p < 4; p++) begin
      if (p != int'(origin)) r[p*3 +: 3] = (t == 2'd1) ? 3'd1 : 3'd2;
    end
    return r;
  endfunction

  // Expected enable pattern: only the origin drives EN_WR or EN_RD.
  function automatic logic [11:0] en_pat(input logic [1:0] origin, input logic [TW-1:0] t);
    logic [11:0] r;
    r = '0;
    r[int'(origin)*3 +: 3] = (t == 2'd1) ? 3'd3 : 3'd4;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input entry_t e, input logic [3:0] a);
    broad_valid  = v;
    broad_type   = e.btype;
    broad_cpu_id = e.origin;
    broad_id     = e.id;
    broad_addr   = e.addr;
    acks         = a;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_take(output entry_t c);
    check("sb_entry_available", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) c = exp_q.pop_front();
    else c = '{id: '0, addr: '0, origin: 2'd0, btype: 2'd0};
  endtask

  // Compare the cycle after a pop against the scoreboard entry.
  task automatic check_output(input string tag, input entry_t c);
    check({tag, "_id"},    64'(active_id), 64'(c.id));
    check({tag, "_addr"},  64'(cbus_addr), 64'(c.addr));
    check({tag, "_snoop"}, 64'(cmds), 64'(snoop_pat(c.origin, c.btype)));
    check({tag, "_busy"},  64'(busy), 64'd1);
  endtask

  initial begin
    entry_t e, cur, blank;
    int     pops, last_pop;
    logic   pend;
    logic [3:0] resp;

    blank = '{id: '0, addr: '0, origin: 2'd0, btype: 2'd0};

    // ---------------- reset, with a valid entry offered ----------------
    rst = 1'b0;
    e = '{id: 5'd17, addr: 32'hDEAD_0000, origin: 2'd1, btype: 2'd1};
    apply_stimulus(1'b1, e, 4'b1111);
    next_cycle;
    next_cycle;
    #1;
    check("rst_pop",   64'(broad_pop), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_cmds",  64'(cmds), 64'd0);
    check("rst_addr",  64'(cbus_addr), 64'd0);
    check("rst_id",    64'(active_id), 64'd0);
`ifdef MESI_ISC_SNOOP_TIMEOUT_EN
    check("rst_tmo",   64'(snoop_timeout), 64'd0);
`endif
    apply_stimulus(1'b0, blank, 4'b0000);
    #1;
    rst = 1'b1;
    next_cycle;

    // ---------------- origin 0 WR, all acks one cycle into snoop -------
    e = '{id: 5'd3, addr: 32'h0000_0001, origin: 2'd0, btype: 2'd1};
    exp_q.push_back(e);
    apply_stimulus(1'b1, e, 4'b0000);
    #1;
    check("t1_pop", 64'(broad_pop), 64'd1);
    sb_take(cur);
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b1110);
    #1;
    check_output("t1", cur);
    check("t1_pop_low", 64'(broad_pop), 64'd0);
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0001);
    #1;
    check("t1_enable", 64'(cmds), 64'(en_pat(2'd0, 2'd1)));
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0000);
    #1;
    check("t1_idle_cmds", 64'(cmds), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);
    next_cycle;

    // ---------------- origin 1 RD, staggered acks ----------------------
    e = '{id: 5'd7, addr: 32'hABCD_0040, origin: 2'd1, btype: 2'd2};
    exp_q.push_back(e);
    apply_stimulus(1'b1, e, 4'b0000);
    #1;
    check("t2_pop", 64'(broad_pop), 64'd1);
    sb_take(cur);
    next_cycle;                                     // +0
    apply_stimulus(1'b0, blank, 4'b0000);
    #1;
    check_output("t2", cur);
    next_cycle;                                     // +1 ack2
    apply_stimulus(1'b0, blank, 4'b0100);
    #1;
    check("t2_p1", 64'(cmds), 64'h482);             // {2,2,0,2}
    next_cycle;                                     // +2
    apply_stimulus(1'b0, blank, 4'b0000);
    #1;
    check("t2_p2", 64'(cmds), 64'h402);             // {2,0,0,2}
    next_cycle;                                     // +3 ack0
    apply_stimulus(1'b0, blank, 4'b0001);
    #1;
    check("t2_p3", 64'(cmds), 64'h402);
    next_cycle;                                     // +4
    apply_stimulus(1'b0, blank, 4'b0110);           // acks on NOP ports
    #1;
    check("t2_p4", 64'(cmds), 64'h400);             // {2,0,0,0}
    next_cycle;                                     // +5 ack3
    apply_stimulus(1'b0, blank, 4'b1000);
    #1;
    check("t2_p5", 64'(cmds), 64'h400);
    next_cycle;                                     // +6 EN_RD on port 1
    apply_stimulus(1'b0, blank, 4'b0010);
    #1;
    check("t2_enable", 64'(cmds), 64'(en_pat(2'd1, 2'd2)));
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0000);
    #1;
    check("t2_idle", 64'(busy), 64'd0);
    next_cycle;

    // ------ origin 0, type 3 (read), spurious origin acks in snoop -----
    e = '{id: 5'd9, addr: 32'h0000_0100, origin: 2'd0, btype: 2'd3};
    exp_q.push_back(e);
    apply_stimulus(1'b1, e, 4'b0001);
    #1;
    check("t3_pop", 64'(broad_pop), 64'd1);
    sb_take(cur);
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0001);
    #1;
    check_output("t3", cur);
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0111);
    #1;
    check("t3_spurious", 64'(cmds), 64'h490);       // {2,2,2,0}
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0001);
    #1;
    check("t3_partial", 64'(cmds), 64'h400);        // {2,0,0,0}
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b1000);
    #1;
    check("t3_still_snoop", 64'(cmds), 64'h400);
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0001);
    #1;
    check("t3_enable", 64'(cmds), 64'(en_pat(2'd0, 2'd3)));
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0000);
    #1;
    check("t3_idle", 64'(busy), 64'd0);
    next_cycle;

    // ---------- two back-to-back entries, instant-ack responder --------
    e = '{id: 5'd21, addr: 32'h0000_2000, origin: 2'd2, btype: 2'd1};
    fifo_q.push_back(e);
    exp_q.push_back(e);
    e = '{id: 5'd22, addr: 32'h0000_3000, origin: 2'd3, btype: 2'd2};
    fifo_q.push_back(e);
    exp_q.push_back(e);
    pops     = 0;
    last_pop = -1;
    pend     = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      resp = 4'b0000;
      for (int p = 0; p < 4; p++) begin
        if (cmds[p*3 +: 3] != 3'd0) resp[p] = 1'b1;
      end
      if (fifo_q.size() != 0) apply_stimulus(1'b1, fifo_q[0], resp);
      else apply_stimulus(1'b0, blank, resp);
      #1;
      if (pend) begin
        check_output("t4", cur);
        pend = 1'b0;
      end
      if (broad_pop) begin
        pops++;
        if (pops == 2) check("t4_gap", 64'(cyc - last_pop), 64'd3);
        last_pop = cyc;
        if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        sb_take(cur);
        pend = 1'b1;
      end
      next_cycle;
    end
    check("t4_pop_count", 64'(pops), 64'd2);
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- reset during snoop, then normal pop --------------
    e = '{id: 5'd12, addr: 32'h0000_5550, origin: 2'd3, btype: 2'd1};
    exp_q.push_back(e);
    apply_stimulus(1'b1, e, 4'b0000);
    #1;
    check("t5_pop", 64'(broad_pop), 64'd1);
    sb_take(cur);
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0000);
    #1;
    check_output("t5", cur);
    rst = 1'b0;
    #1;
    check("t5_rst_cmds", 64'(cmds), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_addr", 64'(cbus_addr), 64'd0);
    check("t5_rst_id",   64'(active_id), 64'd0);
    next_cycle;
    rst = 1'b1;
    next_cycle;
    e = '{id: 5'd13, addr: 32'h0000_6660, origin: 2'd2, btype: 2'd2};
    exp_q.push_back(e);
    apply_stimulus(1'b1, e, 4'b0000);
    #1;
    check("t5_new_pop", 64'(broad_pop), 64'd1);
    sb_take(cur);
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b1011);
    #1;
    check_output("t5_new", cur);
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0100);
    #1;
    check("t5_enable", 64'(cmds), 64'(en_pat(2'd2, 2'd2)));
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0000);
    #1;
    check("t5_idle", 64'(busy), 64'd0);
    next_cycle;

`ifdef MESI_ISC_SNOOP_TIMEOUT_EN
    // ---------------- port 3 never acks: forced enable -----------------
    e = '{id: 5'd30, addr: 32'h0000_0040, origin: 2'd2, btype: 2'd1};
    exp_q.push_back(e);
    apply_stimulus(1'b1, e, 4'b0000);
    #1;
    sb_take(cur);
    next_cycle;                                     // snoop cycle 1
    apply_stimulus(1'b0, blank, 4'b0011);
    #1;
    check_output("t6", cur);
    for (int i = 2; i <= 8; i++) begin
      next_cycle;
      apply_stimulus(1'b0, blank, 4'b0000);
    end
    #1;
    check("t6_last_snoop", 64'(cmds), 64'h200);     // {1,0,0,0}
    check("t6_tmo_before", 64'(snoop_timeout), 64'd0);
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0100);
    #1;
    check("t6_enable", 64'(cmds), 64'(en_pat(2'd2, 2'd1)));
    check("t6_tmo_set", 64'(snoop_timeout), 64'd1);
    next_cycle;
    apply_stimulus(1'b0, blank, 4'b0000);
    #1;
    check("t6_idle", 64'(busy), 64'd0);
    check("t6_tmo_sticky", 64'(snoop_timeout), 64'd1);
    next_cycle;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
